// File: rtl/uart_rx_byte.sv
// uart_rx_byte: UART receiver that turns the serial line into bytes (8N1, or 8E1).
//
// Receives bytes sent by a PC terminal on the board's UART_RXD pin.
// A valid byte is reported with a one-cycle strobe.
//
// Build option:
//   UART_RX_PARITY_EN  When defined, an even parity bit follows the 8 data bits.
//                      When undefined, the frame has no parity bit and parity_err
//                      is tied to 0. The port exists in both builds.
//
// Ports:
//   clk         in   system clock (CLOCK_50)
//   rst         in   asynchronous active-low reset; all state clears while low
//   rx          in   serial line, idle high, asynchronous to clk
//   data  [7:0] out  last correctly framed byte
//   valid       out  one-cycle strobe; data is new in this cycle
//   busy        out  high whenever the receiver is not idle
//   frame_err   out  result of the last stop-bit check (a status flag, not a strobe)
//   parity_err  out  result of the last parity check (a status flag, not a strobe)
//
// Handshake: valid is a one-cycle strobe with no ready. A consumer that is not
// ready loses the byte, but data keeps its value until the next good frame.
module uart_rx_byte #(
   parameter int CLK_FREQ     = 50000000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       busy,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic          rx_meta_q, rx_s_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          frame_err_q, frame_err_d;
   logic          half_end, bit_end;
   logic          par_ok;

   assign half_end = (cnt_q == CNT_HALF_END);
   assign bit_end  = (cnt_q == CNT_BIT_END);

`ifdef UART_RX_PARITY_EN
   logic parity_bit_q, parity_bit_d;
   logic parity_err_q, parity_err_d;
   // Even parity: data bits XOR parity bit must be 0.
   assign par_ok     = ~(^{shift_q, parity_bit_q});
   assign parity_err = parity_err_q;
`else
   assign par_ok     = 1'b1;
   assign parity_err = 1'b0;
`endif

   // State register and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         cnt_q        <= '0;
         idx_q        <= 3'd0;
         shift_q      <= 8'h00;
         data_q       <= 8'h00;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bit_q <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rx_meta_q    <= rx;
         rx_s_q       <= rx_meta_q;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
         parity_bit_q <= parity_bit_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (!rx_s_q) state_d = S_START;
         // A start bit that is gone again at its midpoint is a glitch.
         S_START:  if (half_end) state_d = rx_s_q ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
         S_DATA:   if (bit_end && idx_q == 3'd7) state_d = S_PARITY;
`else
         S_DATA:   if (bit_end && idx_q == 3'd7) state_d = S_STOP;
`endif
         S_PARITY: if (bit_end) state_d = S_STOP;
         // A low stop bit means a break or a bad frame. Wait for the line to go idle.
         S_STOP:   if (bit_end) state_d = rx_s_q ? S_IDLE : S_BREAK;
         S_BREAK:  if (rx_s_q) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath and output logic. After START the counter is aligned to
   // mid-bit, so each bit_end falls on the midpoint of the next bit.
   always_comb begin
      cnt_d        = '0;
      idx_d        = idx_q;
      shift_d      = shift_q;
      data_d       = data_q;
      valid_d      = 1'b0;
      frame_err_d  = frame_err_q;
`ifdef UART_RX_PARITY_EN
      parity_bit_d = parity_bit_q;
      parity_err_d = parity_err_q;
`endif
      case (state_q)
         S_START: begin
            if (half_end) idx_d = 3'd0;
            else          cnt_d = cnt_q + CW'(1);
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = {rx_s_q, shift_q[7:1]};  // LSB arrives first
               idx_d   = idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_PARITY: begin
            if (bit_end) begin
`ifdef UART_RX_PARITY_EN
               parity_bit_d = rx_s_q;
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               frame_err_d = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
               parity_err_d = ~par_ok;
`endif
               if (rx_s_q && par_ok) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: ;
      endcase
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign busy      = (state_q != S_IDLE);
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: self-checking bench for uart_rx_byte at 16 clocks per bit.
// The reference model is the frame itself. Each good frame pushes its byte and
// its start time. A receive monitor pops them when valid fires.
module tb_uart_rx_byte;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int LAT   = 2 + HALF + (NBITS - 1) * CPB;
   localparam int FRAME = NBITS * CPB;

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       busy;
   logic       frame_err;
   logic       parity_err;

   uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .data       (data),
      .valid      (valid),
      .busy       (busy),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [7:0] exp_q[$];
   int         start_q[$];
   logic [7:0] last_data = 8'h00;
   logic       exp_fe    = 1'b0;
   logic       exp_pe    = 1'b0;
   int         n_checks  = 0;
   int         n_pass    = 0;
   int         last_valid_cyc = 0;
   int         prev_valid_cyc = 0;
   logic       prev_valid = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      n_checks++;
      if (obs === expd) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, expd, cyc);
   endtask

   // ---------------- receive monitor ----------------
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         check("valid_width", 32'(prev_valid), 32'd0);
         if (exp_q.size() == 0) begin
            check("valid_unexpected", 32'(valid), 32'd0);
         end else begin
            logic [7:0] eb;
            int st, lat;
            eb  = exp_q.pop_front();
            st  = start_q.pop_front();
            lat = cyc - st;
            check("rx_data", 32'(data), 32'(eb));
            check("latency_window", 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'd1);
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
         end
      end
      prev_valid = valid;
   end

   // ---------------- driver tasks ----------------
   task automatic drive_bit(input logic b, input int n);
      rx = b;
      repeat (n) @(negedge clk);
   endtask

   // Send one frame, update the model, and check the status after the stop bit.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_good,
                             input int idle);
      logic good;
      good = stop;
`ifdef UART_RX_PARITY_EN
      good = stop && par_good;
`endif
      if (good) begin
         exp_q.push_back(b);
         start_q.push_back(cyc);
      end
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
`ifdef UART_RX_PARITY_EN
      drive_bit(par_good ? (^b) : ~(^b), CPB);
      exp_pe = ~par_good;
`endif
      exp_fe = ~stop;
      if (good) last_data = b;
      drive_bit(stop, CPB);
      check("frame_err", 32'(frame_err), 32'(exp_fe));
      check("parity_err", 32'(parity_err), 32'(exp_pe));
      check("data_hold", 32'(data), 32'(last_data));
      if (idle > 0) begin
         drive_bit(1'b1, idle * CPB);
         check("idle_busy", 32'(busy), 32'd0);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic saw_busy;
      rst = 1'b0;
      rx  = 1'b1;
      repeat (4) @(negedge clk);
      check("reset_data", 32'(data), 32'h00);
      check("reset_valid", 32'(valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      check("reset_parity_err", 32'(parity_err), 32'd0);
      rst = 1'b1;
      repeat (CPB) @(negedge clk);

      // Two frames with one idle bit each.
      send_frame(8'h55, 1'b1, 1'b1, 1);
      send_frame(8'hA3, 1'b1, 1'b1, 1);

      // Back-to-back frames with zero idle bits.
      send_frame(8'h00, 1'b1, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 1'b1, 1);
      check("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'(FRAME));

      // Short glitch: busy rises, then falls, and nothing else happens.
      saw_busy = 1'b0;
      rx = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
      end
      rx = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
      end
      check("glitch_busy_seen", 32'(saw_busy), 32'd1);
      check("glitch_busy_clear", 32'(busy), 32'd0);
      check("glitch_data", 32'(data), 32'(last_data));
      check("glitch_frame_err", 32'(frame_err), 32'(exp_fe));

      // Bad stop bit followed by a held-low line.
      send_frame(8'h3C, 1'b0, 1'b1, 0);
      drive_bit(1'b0, 40);
      check("break_busy", 32'(busy), 32'd1);
      drive_bit(1'b1, CPB);
      check("break_release_busy", 32'(busy), 32'd0);
      send_frame(8'h7E, 1'b1, 1'b1, 1);

      // Reset after four data bits of 0x81.
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive_bit(1'(8'h81 >> i), CPB);
      rst = 1'b0;
      #1;
      check("midrst_data", 32'(data), 32'h00);
      check("midrst_valid", 32'(valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_frame_err", 32'(frame_err), 32'd0);
      check("midrst_parity_err", 32'(parity_err), 32'd0);
      last_data = 8'h00;
      exp_fe    = 1'b0;
      exp_pe    = 1'b0;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (CPB) @(negedge clk);
      send_frame(8'h81, 1'b1, 1'b1, 1);

`ifdef UART_RX_PARITY_EN
      // Parity: 0x07 has three ones, so the even parity bit is 1.
      send_frame(8'h07, 1'b1, 1'b1, 1);
      send_frame(8'h07, 1'b1, 1'b0, 1);
      send_frame(8'h5A, 1'b1, 1'b1, 1);
`endif

      // Random bytes with 0..2 idle bits between them.
      for (int n = 0; n < 24; n++) begin
         send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1, int'($urandom_range(0, 2)));
      end
      drive_bit(1'b1, 2 * CPB);

      check("all_bytes_received", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
